beta_alu_arbiter: RTL and testbench
===================================

BETA_ALU_ARBITER -- requirements
Module: beta_alu_arbiter

Interface
REQ-001 SHALL have parameter MUL_LAT, default 3, giving EXEC-to-result cycles for multiply; MUL_LAT<1 SHALL be an elaboration error.
REQ-002 SHALL have port clk  input  1  sole clock; all state rising-edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports reqN_valid  input  1  request N (N=0,1) presents an operation.
REQ-005 SHALL have ports reqN_ready  output  1  request N accepted this cycle.
REQ-006 SHALL have ports reqN_fn  input  4  ALU function code; reqN_a, reqN_b  input  32  operands.
REQ-007 SHALL have ports rspN_valid  output  1  result for requester N available.
REQ-008 SHALL have ports rspN_ready  input  1  requester N consumes result.
REQ-009 SHALL have ports rspN_result  output  32  result, valid while rspN_valid=1.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-011 SHALL share one Beta_ALU instance between two requesters, one operation in flight.
REQ-012 SHALL implement FSM IDLE, EXEC, WAIT, RESP.
REQ-013 IDLE: SHALL grant one valid requester; reqN_ready combinational = (state==IDLE) & grantN & reqN_valid.
REQ-014 Grant: only one valid -> that one, regardless of pointer; both valid -> requester named by 1-bit round-robin pointer.
REQ-015 On accept edge SHALL capture fn, a, b, owner id into registers; ALU inputs driven only from these registers.
REQ-016 IDLE->EXEC on accept; EXEC->RESP when captured fn != FN_MUL, capturing ALU Result into result register.
REQ-017 EXEC->WAIT when fn == FN_MUL and MUL_LAT>1; WAIT counts MUL_LAT-1 cycles then captures Result and goes to RESP; MUL_LAT==1 treats MUL as non-MUL.
REQ-018 Latency, accept at cycle T: rsp_valid first high in T+2 (non-MUL), T+1+MUL_LAT (MUL).
REQ-019 RESP: rspN_valid high only for owner; rspN_result = result register, stable until handshake.
REQ-020 RESP->IDLE on edge with rsp_valid & rsp_ready; pointer then set to the non-owner.
REQ-021 rsp_ready low SHALL hold RESP indefinitely; no new grant; both reqN_ready low.
REQ-022 reqN_valid dropping before accept SHALL have no effect; no request captured outside IDLE.
REQ-023 rspN_result for non-owner SHALL be driven 0.

Reset
REQ-024 rst SHALL force immediately: state IDLE, pointer=0 (req0 priority), counter 0, result 0, captured regs 0.
REQ-025 Outputs during/after reset: reqN_ready 0 unless IDLE grant, rspN_valid 0, busy 0.
REQ-026 Reset mid-operation (EXEC/WAIT/RESP) SHALL discard the operation; no response ever issued for it.

Structure
REQ-027 Package beta_alu_pkg SHALL hold FN_ADD 4'b0000, FN_SUB 4'b0001, FN_MUL 4'b0010, FN_CMPEQ 4'b0100, FN_CMPLT 4'b0101, FN_CMPLE 4'b0110, FN_AND 4'b1000, FN_XOR 4'b1010, FN_SHL 4'b1100, FN_SHR 4'b1101, FN_SRA 4'b1110, and the FSM state enum.
REQ-028 Grant logic SHALL be a sub-module rr_arbiter2 (two valids, pointer in; one-hot grant out).

Verification
REQ-029 req0 FN_ADD a=5 b=7, rsp0_ready=1 -> ready0 in T, rsp0_valid in T+2, result 32'd12.
REQ-030 req1 FN_SUB a=3 b=5 -> rsp1_result 32'hFFFFFFFE at T+2; rsp0_valid stays 0.
REQ-031 After reset, both valid FN_ADD (1+1, 2+2) held -> req0 served first (2), then req1 (4); next simultaneous pair -> req0 again after req1 served.
REQ-032 MUL_LAT=3, req0 FN_MUL 6*7 -> rsp0_valid first at T+4, result 32'd42; busy high T+1..T+4.
REQ-033 rsp0_ready low 5 cycles with req1_valid high -> result held, ready1 low throughout; req1 granted in the cycle after the rsp0 handshake.
REQ-034 rst pulsed during WAIT -> rsp0_valid never asserts for that op; busy 0; next request completes normally.

Source files
------------

// File: rtl/beta_alu_pkg.sv
// beta_alu_pkg: ALU function codes and arbiter FSM states shared by the Beta ALU arbiter.
package beta_alu_pkg;
   localparam logic [3:0] FN_ADD   = 4'b0000;
   localparam logic [3:0] FN_SUB   = 4'b0001;
   localparam logic [3:0] FN_MUL   = 4'b0010;
   localparam logic [3:0] FN_CMPEQ = 4'b0100;
   localparam logic [3:0] FN_CMPLT = 4'b0101;
   localparam logic [3:0] FN_CMPLE = 4'b0110;
   localparam logic [3:0] FN_AND   = 4'b1000;
   localparam logic [3:0] FN_XOR   = 4'b1010;
   localparam logic [3:0] FN_SHL   = 4'b1100;
   localparam logic [3:0] FN_SHR   = 4'b1101;
   localparam logic [3:0] FN_SRA   = 4'b1110;
   typedef enum logic [1:0] {IDLE, EXEC, WAIT, RESP} state_t;
endpackage

// File: rtl/beta_alu.sv
// beta_alu: combinational Beta ALU; comparisons return 0/1, shifts use b[4:0].
module beta_alu
   import beta_alu_pkg::*;
(
   input  logic [3:0]  fn,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] result
);
   always_comb begin
      result = '0;
      case (fn)
         FN_ADD:   result = a + b;
         FN_SUB:   result = a - b;
         FN_MUL:   result = a * b;
         FN_CMPEQ: result = {31'b0, a == b};
         FN_CMPLT: result = {31'b0, $signed(a) < $signed(b)};
         FN_CMPLE: result = {31'b0, $signed(a) <= $signed(b)};
         FN_AND:   result = a & b;
         FN_XOR:   result = a ^ b;
         FN_SHL:   result = a << b[4:0];
         FN_SHR:   result = a >> b[4:0];
         FN_SRA:   result = $signed(a) >>> b[4:0];
         default:  result = '0;
      endcase
   end
endmodule

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way grant; a lone valid always wins, a tie goes to the pointer.
module rr_arbiter2 (
   input  logic [1:0] valid,
   input  logic       ptr,
   output logic [1:0] grant
);
   assign grant[0] = valid[0] & (~valid[1] | ~ptr);
   assign grant[1] = valid[1] & (~valid[0] | ptr);
endmodule

// File: rtl/beta_alu_arbiter.sv
// beta_alu_arbiter: shares one Beta ALU between two requesters, one operation in flight.
module beta_alu_arbiter
   import beta_alu_pkg::*;
#(
   parameter int MUL_LAT = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [3:0]  req0_fn,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [3:0]  req1_fn,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic [31:0] rsp0_result,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [31:0] rsp1_result,
   output logic        busy
);
   if (MUL_LAT < 1) begin : g_bad_lat
      $error("beta_alu_arbiter: MUL_LAT must be at least 1");
   end
   localparam int CW = $clog2(MUL_LAT + 1);
   state_t      state;
   logic        ptr, owner;
   logic [3:0]  fn_q;
   logic [31:0] a_q, b_q, result_q, alu_y;
   logic [CW-1:0] cnt;
   logic [1:0]  grant;
   logic        is_mul, rsp_hs;
   rr_arbiter2 u_arb (.valid({req1_valid, req0_valid}), .ptr(ptr), .grant(grant));
   beta_alu u_alu (.fn(fn_q), .a(a_q), .b(b_q), .result(alu_y));
   assign req0_ready  = (state == IDLE) & grant[0] & req0_valid;
   assign req1_ready  = (state == IDLE) & grant[1] & req1_valid;
   assign rsp0_valid  = (state == RESP) & ~owner;
   assign rsp1_valid  = (state == RESP) & owner;
   assign rsp0_result = rsp0_valid ? result_q : '0;
   assign rsp1_result = rsp1_valid ? result_q : '0;
   assign busy        = state != IDLE;
   assign is_mul      = (fn_q == FN_MUL) && (MUL_LAT > 1);
   assign rsp_hs      = owner ? (rsp1_valid & rsp1_ready) : (rsp0_valid & rsp0_ready);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         ptr      <= 1'b0;
         owner    <= 1'b0;
         fn_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         cnt      <= '0;
      end else begin
         case (state)
            IDLE: if (req0_ready | req1_ready) begin
               owner <= req1_ready;
               fn_q  <= req1_ready ? req1_fn : req0_fn;
               a_q   <= req1_ready ? req1_a  : req0_a;
               b_q   <= req1_ready ? req1_b  : req0_b;
               state <= EXEC;
            end
            EXEC: if (is_mul) begin
               cnt   <= CW'(MUL_LAT - 1);
               state <= WAIT;
            end else begin
               result_q <= alu_y;
               state    <= RESP;
            end
            // cnt holds the remaining multiply cycles; capture on the last one
            WAIT: if (cnt == CW'(1)) begin
               result_q <= alu_y;
               cnt      <= '0;
               state    <= RESP;
            end else begin
               cnt <= cnt - CW'(1);
            end
            RESP: if (rsp_hs) begin
               ptr   <= ~owner;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_beta_alu_arbiter.sv
// tb_beta_alu_arbiter: vector table, corner sequences and random traffic against a latency-level model.
module tb_beta_alu_arbiter;
   import beta_alu_pkg::*;
   localparam int MUL_LAT = 3;
   logic clk = 0, rst = 1;
   logic req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
   logic [3:0] req0_fn = 0, req1_fn = 0;
   logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
   logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
   logic [31:0] rsp0_result, rsp1_result;
   int n_vec = 0, n_err = 0;
   bit m_busy, m_resp, m_owner, m_ptr, e_r0, e_r1;
   int m_wait;
   logic [31:0] m_res;
   typedef struct {bit req; logic [3:0] fn; logic [31:0] a, b, exp;} vec_t;
   vec_t tbl[12];
   logic [3:0] fns[11];
   beta_alu_arbiter #(.MUL_LAT(MUL_LAT)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_fn(req0_fn), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_fn(req1_fn), .req1_a(req1_a), .req1_b(req1_b),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
      .busy(busy));
   always #5 clk = ~clk;
   function automatic logic [31:0] alu_ref(logic [3:0] fn, logic [31:0] a, logic [31:0] b);
      int sh;
      sh = int'(b % 32);
      case (fn)
         FN_ADD:   return a + b;
         FN_SUB:   return a - b;
         FN_MUL:   return a * b;
         FN_CMPEQ: return (a == b) ? 1 : 0;
         FN_CMPLT: return (int'(a) <  int'(b)) ? 1 : 0;
         FN_CMPLE: return (int'(a) <= int'(b)) ? 1 : 0;
         FN_AND:   return a & b;
         FN_XOR:   return a ^ b;
         FN_SHL:   return a << sh;
         FN_SHR:   return a >> sh;
         FN_SRA:   return 32'(int'(a) >>> sh);
         default:  return 0;
      endcase
   endfunction
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic model_reset();
      m_busy = 0; m_resp = 0; m_owner = 0; m_ptr = 0; m_wait = 0; m_res = 0;
   endtask
   task automatic check();
      e_r0 = !m_busy && req0_valid && (!req1_valid || !m_ptr);
      e_r1 = !m_busy && req1_valid && (!req0_valid || m_ptr);
      chk("req0_ready", req0_ready, e_r0);
      chk("req1_ready", req1_ready, e_r1);
      chk("rsp0_valid", rsp0_valid, m_resp && !m_owner);
      chk("rsp1_valid", rsp1_valid, m_resp && m_owner);
      chk("busy", busy, m_busy);
      if (m_resp) begin
         chk("rsp0_result", rsp0_result, m_owner ? 0 : m_res);
         chk("rsp1_result", rsp1_result, m_owner ? m_res : 0);
      end
   endtask
   task automatic tick();
      bit acc, hs, own;
      logic [31:0] res;
      acc = !m_busy && (e_r0 || e_r1);
      hs  = m_resp && (m_owner ? rsp1_ready : rsp0_ready);
      own = e_r1;
      res = own ? alu_ref(req1_fn, req1_a, req1_b) : alu_ref(req0_fn, req0_a, req0_b);
      @(posedge clk);
      if (acc) begin
         m_busy = 1; m_resp = 0; m_owner = own; m_res = res;
         m_wait = ((own ? req1_fn : req0_fn) == FN_MUL) ? MUL_LAT : 1;
      end else if (m_busy && !m_resp) begin
         m_wait--;
         if (m_wait == 0) m_resp = 1;
      end else if (hs) begin
         m_busy = 0; m_resp = 0; m_ptr = !m_owner;
      end
      #1;
   endtask
   task automatic cyc();
      #4 check();
      tick();
   endtask
   task automatic run_op(bit req, logic [3:0] fn, logic [31:0] a, logic [31:0] b, logic [31:0] exp);
      bit ok = 0;
      int lat = 1;
      rsp0_ready = 1; rsp1_ready = 1;
      if (req) begin req1_valid = 1; req1_fn = fn; req1_a = a; req1_b = b; end
      else begin req0_valid = 1; req0_fn = fn; req0_a = a; req0_b = b; end
      for (int i = 0; i < 20 && !ok; i++) begin
         #4 check();
         ok = req ? e_r1 : e_r0;
         tick();
      end
      req0_valid = 0; req1_valid = 0;
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         #4 check();
         ok = req ? rsp1_valid : rsp0_valid;
         if (!ok) begin tick(); lat++; end
      end
      chk("op_done", 32'(ok), 1);
      chk("op_latency", lat, (fn == FN_MUL) ? MUL_LAT + 1 : 2);
      chk("op_result", req ? rsp1_result : rsp0_result, exp);
      tick();
   endtask
   initial begin
      bit port_q[$];
      logic [31:0] res_q[$];
      fns = '{FN_ADD, FN_SUB, FN_MUL, FN_CMPEQ, FN_CMPLT, FN_CMPLE, FN_AND, FN_XOR, FN_SHL, FN_SHR, FN_SRA};
      tbl = '{
         '{0, FN_ADD,   32'd5,          32'd7,          32'd12},
         '{1, FN_SUB,   32'd3,          32'd5,          32'hFFFFFFFE},
         '{0, FN_MUL,   32'd6,          32'd7,          32'd42},
         '{1, FN_CMPEQ, 32'd9,          32'd9,          32'd1},
         '{0, FN_CMPLT, 32'hFFFFFFFF,   32'd1,          32'd1},
         '{1, FN_CMPLT, 32'd5,          32'd5,          32'd0},
         '{0, FN_CMPLE, 32'd5,          32'd5,          32'd1},
         '{1, FN_AND,   32'hF0F0FF00,   32'h0FF0F0F0,   32'h00F0F000},
         '{0, FN_XOR,   32'hFF00FF00,   32'h0FF00FF0,   32'hF0F0F0F0},
         '{1, FN_SHL,   32'd1,          32'd31,         32'h80000000},
         '{0, FN_SHR,   32'h80000000,   32'd4,          32'h08000000},
         '{1, FN_SRA,   32'h80000000,   32'd4,          32'hF8000000}};
      model_reset();
      #1;
      chk("reset_busy", busy, 0);
      chk("reset_rsp0_valid", rsp0_valid, 0);
      chk("reset_rsp1_valid", rsp1_valid, 0);
      chk("reset_req0_ready", req0_ready, 0);
      @(posedge clk); #1 rst = 0;
      // simultaneous requests held: req0, req1, then req0 again
      req0_valid = 1; req0_fn = FN_ADD; req0_a = 1; req0_b = 1;
      req1_valid = 1; req1_fn = FN_ADD; req1_a = 2; req1_b = 2;
      rsp0_ready = 1; rsp1_ready = 1;
      for (int i = 0; i < 40 && port_q.size() < 3; i++) begin
         #4 check();
         if (rsp0_valid || rsp1_valid) begin port_q.push_back(rsp1_valid); res_q.push_back(rsp1_valid ? rsp1_result : rsp0_result); end
         tick();
      end
      req0_valid = 0; req1_valid = 0;
      chk("rr_count", port_q.size(), 3);
      while (port_q.size() < 3) begin port_q.push_back(1'bx); res_q.push_back('x); end
      chk("rr_first_port", 32'(port_q[0]), 0);
      chk("rr_first_res", res_q[0], 2);
      chk("rr_second_port", 32'(port_q[1]), 1);
      chk("rr_second_res", res_q[1], 4);
      chk("rr_third_port", 32'(port_q[2]), 0);
      chk("rr_third_res", res_q[2], 2);
      cyc();
      foreach (tbl[i]) run_op(tbl[i].req, tbl[i].fn, tbl[i].a, tbl[i].b, tbl[i].exp);
      // response back-pressure while the other requester waits
      rsp0_ready = 0; rsp1_ready = 1;
      req0_valid = 1; req0_fn = FN_ADD; req0_a = 10; req0_b = 20;
      for (int i = 0; i < 10 && !e_r0; i++) cyc();
      req0_valid = 0;
      req1_valid = 1; req1_fn = FN_SUB; req1_a = 50; req1_b = 8;
      for (int i = 0; i < 10 && !rsp0_valid; i++) cyc();
      for (int i = 0; i < 5; i++) begin
         #4 check();
         chk("hold_result", rsp0_result, 30);
         chk("hold_ready1", req1_ready, 0);
         tick();
      end
      rsp0_ready = 1;
      cyc();
      #4 check();
      chk("grant_after_hs", req1_ready, 1);
      tick();
      req1_valid = 0;
      for (int i = 0; i < 10 && !rsp1_valid; i++) cyc();
      #4 check();
      chk("held_req1_result", rsp1_result, 42);
      tick();
      // reset in the middle of a multiply
      req0_valid = 1; req0_fn = FN_MUL; req0_a = 6; req0_b = 7;
      for (int i = 0; i < 10 && !e_r0; i++) cyc();
      req0_valid = 0;
      cyc();
      #2 rst = 1;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_rsp0_valid", rsp0_valid, 0);
      model_reset();
      @(posedge clk); #1 rst = 0;
      for (int i = 0; i < 8; i++) cyc();
      run_op(0, FN_ADD, 32'd100, 32'd23, 32'd123);
      // random traffic
      for (int i = 0; i < 600; i++) begin
         req0_valid = 1'($urandom_range(0, 1));
         req1_valid = 1'($urandom_range(0, 1));
         req0_fn = fns[$urandom_range(0, 10)];
         req1_fn = fns[$urandom_range(0, 10)];
         req0_a = $urandom; req0_b = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
         req1_a = $urandom; req1_b = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
         rsp0_ready = ($urandom_range(0, 3) != 0);
         rsp1_ready = ($urandom_range(0, 3) != 0);
         cyc();
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
